mac_operand_skewer: RTL and testbench

//  Upstream feeder for a row/column of mac_cell instances in the systolic array.
//  - Accepts one operand vector (LANES elements) per cycle over a valid/ready handshake.
//  - Buffers vectors in a DEPTH-entry FIFO.
//  - Emits them diagonally skewed: lane i is delayed i cycles, so element i reaches
//    MAC cell i in step with the partial data flowing through the array.
//  - Drives the cells' en and flags end-of-stream.

---
 rtl/mac_operand_skewer.sv | 230 +++++++++++++++++++++++
 tb/tb_mac_operand_skewer.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_skewer.sv
// ---------------------------------------------------------------------------
// mac_operand_skewer
//
// Upstream feeder for one edge of the systolic MAC array. Operand vectors of
// LANES signed elements are accepted over a valid/ready handshake, buffered
// in a DEPTH-entry FIFO, and emitted diagonally skewed so that lane i reaches
// MAC cell i i cycles after lane 0. A small FSM tracks the stream. It pulses
// done when the final lane of the s_last vector leaves the skewer.
//
// Datapath:
//   - A popped FIFO head first lands in a shared stage-0 register.
//   - Lane i then runs through a private chain of i+1 registers.
//   - The lane i output is therefore visible two edges after the pop, plus
//     i further edges.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   s_valid      input vector valid
//   s_ready      FIFO can accept; forced low while draining
//   s_data       input vector; lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_last       marks the final vector of a stream
//   hold         array stall: freezes pop and all skew registers
//   m_data       skewed operands, same lane packing as s_data
//   m_lane_valid per-lane valid for m_data
//   m_en         any lane valid and not held; drives mac_cell en
//   busy         FSM not idle
//   done         one-cycle pulse with the final lane of the s_last vector
//   bubble_cnt   (MACSKEW_STATS_EN only) saturating count of starved
//                streaming cycles
//
// Optional feature macro: MACSKEW_STATS_EN adds the bubble_cnt output.
// ---------------------------------------------------------------------------
module mac_operand_skewer #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [LANES*DATA_WIDTH-1:0] s_data,
    input  logic                        s_last,
    input  logic                        hold,
    output logic [LANES*DATA_WIDTH-1:0] m_data,
    output logic [LANES-1:0]            m_lane_valid,
    output logic                        m_en,
    output logic                        busy,
    output logic                        done
`ifdef MACSKEW_STATS_EN
    ,
    output logic [15:0]                 bubble_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int VEC_W = LANES * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [VEC_W-1:0] fifo_data [DEPTH];
    logic [DEPTH-1:0] fifo_last;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic push;
    logic pop;
    logic head_last;

    // s_ready looks only at registered state, so it never depends on a
    // same-cycle pop: a full FIFO refuses a push even while popping.
    assign s_ready   = (count_q < CNT_W'(DEPTH)) && (state_q != DRAIN);
    assign push      = s_valid && s_ready;
    assign pop       = !hold && (count_q != '0) && (state_q != IDLE);
    assign head_last = fifo_last[rd_ptr_q];

    // Storage needs no reset; only count and pointers define occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr_q] <= s_data;
            fifo_last[wr_ptr_q] <= s_last;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Skew pipeline
    // ------------------------------------------------------------------
    logic [VEC_W-1:0] st0_data_q;
    logic             st0_valid_q;
    logic             st0_last_q;

    // A cycle without a pop injects a zero bubble so the MACs add nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st0_data_q  <= '0;
            st0_valid_q <= 1'b0;
            st0_last_q  <= 1'b0;
        end else if (!hold) begin
            st0_data_q  <= pop ? fifo_data[rd_ptr_q] : '0;
            st0_valid_q <= pop;
            st0_last_q  <= pop && head_last;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] d_q [i+1];
        logic [i:0]            v_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k <= i; k++) begin
                    d_q[k] <= '0;
                end
                v_q <= '0;
            end else if (!hold) begin
                d_q[0] <= st0_data_q[i*DATA_WIDTH +: DATA_WIDTH];
                v_q[0] <= st0_valid_q;
                for (int k = 1; k <= i; k++) begin
                    d_q[k] <= d_q[k-1];
                    v_q[k] <= v_q[k-1];
                end
            end
        end

        assign m_data[i*DATA_WIDTH +: DATA_WIDTH] = d_q[i];
        assign m_lane_valid[i]                    = v_q[i];
    end

    // The last flag rides alongside the slowest lane only.
    logic [LANES-1:0] last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= '0;
        end else if (!hold) begin
            last_q <= {last_q[LANES-2:0], st0_last_q};
        end
    end

    assign m_en = (|m_lane_valid) && !hold;
    assign done = m_lane_valid[LANES-1] && last_q[LANES-1] && !hold;
    assign busy = (state_q != IDLE);

    // ------------------------------------------------------------------
    // Stream FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (push) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (pop && head_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef MACSKEW_STATS_EN
    // ------------------------------------------------------------------
    // Starvation statistics
    // ------------------------------------------------------------------
    logic [15:0] bubble_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else if (state_q == IDLE && push) begin
            bubble_cnt_q <= '0;
        end else if (state_q == STREAM && !hold && count_q == '0
                     && bubble_cnt_q != 16'hFFFF) begin
            bubble_cnt_q <= bubble_cnt_q + 16'd1;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_mac_operand_skewer.sv
// Bench for mac_operand_skewer (DATA_WIDTH=8, LANES=4, DEPTH=4).
// The reference model keeps the FIFO as a queue plus a short history of
// what entered the skewer on each non-held edge. Lane i shows the entry
// from i+1 advances ago. Directed tests pin the model with literal values.
module tb_mac_operand_skewer;

    localparam int W = 8;
    localparam int L = 4;
    localparam int D = 4;

    typedef struct packed {
        logic [L*W-1:0] data;
        logic           valid;
        logic           last;
    } ent_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [L*W-1:0] s_data = '0;
    logic           s_last = 1'b0;
    logic           hold = 1'b0;
    logic [L*W-1:0] m_data;
    logic [L-1:0]   m_lane_valid;
    logic           m_en;
    logic           busy;
    logic           done;
`ifdef MACSKEW_STATS_EN
    logic [15:0]    bubble_cnt;
`endif

    mac_operand_skewer #(
        .DATA_WIDTH(W),
        .LANES     (L),
        .DEPTH     (D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .hold        (hold),
        .m_data      (m_data),
        .m_lane_valid(m_lane_valid),
        .m_en        (m_en),
        .busy        (busy),
        .done        (done)
`ifdef MACSKEW_STATS_EN
        ,
        .bubble_cnt  (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    ent_t mq[$];    // FIFO contents
    ent_t hist[$];  // stage-0 entries, oldest first, always L+1 long
    int   mode;     // 0 idle, 1 stream, 2 drain
    int   mbub;

    function automatic ent_t lane_ent(input int i);
        return hist[L - 1 - i];
    endfunction

    function automatic logic [L*W-1:0] exp_data();
        logic [L*W-1:0] r;
        ent_t e;
        r = '0;
        for (int i = 0; i < L; i++) begin
            e = lane_ent(i);
            r[i*W +: W] = e.data[i*W +: W];
        end
        return r;
    endfunction

    function automatic logic [L-1:0] exp_valid();
        logic [L-1:0] r;
        ent_t e;
        for (int i = 0; i < L; i++) begin
            e = lane_ent(i);
            r[i] = e.valid;
        end
        return r;
    endfunction

    function automatic logic exp_done();
        ent_t e;
        e = lane_ent(L - 1);
        return e.valid && e.last && !hold;
    endfunction

    function automatic logic exp_ready();
        return (mq.size() < D) && (mode != 2);
    endfunction

    always @(posedge clk or posedge rst) begin : model
        ent_t e;
        logic pu, po, dn;
        int   qs, old_mode;
        if (rst) begin
            mq.delete();
            hist.delete();
            for (int k = 0; k <= L; k++) hist.push_back('0);
            mode = 0;
            mbub = 0;
        end else begin
            dn       = exp_done();
            pu       = s_valid && exp_ready();
            qs       = mq.size();
            old_mode = mode;
            po       = !hold && qs > 0 && mode != 0;
            e        = '0;
            if (po) begin
                e = mq[0];
                mq.delete(0);
            end
            if (!hold) begin
                hist.push_back(e);
                hist.delete(0);
            end
            if (pu) mq.push_back('{data: s_data, valid: 1'b1, last: s_last});
            if (old_mode == 1 && !hold && qs == 0 && mbub < 65535) mbub++;
            if (old_mode == 0 && pu) begin
                mode = 1;
                mbub = 0;
            end else if (old_mode == 1 && po && e.last) begin
                mode = 2;
            end else if (old_mode == 2 && dn) begin
                mode = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare against the model
    // ------------------------------------------------------------------
    bit chk_en = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_data", m_data, exp_data());
            chk("m_lane_valid", m_lane_valid, exp_valid());
            chk("m_en", m_en, (|exp_valid()) && !hold);
            chk("done", done, exp_done());
            chk("busy", busy, mode != 0);
            if (!rst) chk("s_ready", s_ready, exp_ready());
`ifdef MACSKEW_STATS_EN
            chk("bubble_cnt", bubble_cnt, mbub);
`endif
        end
    end

    // ------------------------------------------------------------------
    // Observers for the literal tests
    // ------------------------------------------------------------------
    bit         rec = 0;
    logic [7:0] r0[$];
    logic [7:0] r3[$];
    bit         vtr[$];
    bit         mac_on = 0;
    int         acc[L];
    int         idx[L];
    int         top[3] = '{3, 1, -1};
    int         done_cnt = 0;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (rec && !hold) begin
            vtr.push_back(m_lane_valid[0]);
            if (m_lane_valid[0]) r0.push_back(m_data[7:0]);
            if (m_lane_valid[L-1]) r3.push_back(m_data[(L-1)*W +: W]);
        end
        if (mac_on && m_en) begin
            for (int i = 0; i < L; i++) begin
                if (m_lane_valid[i] && idx[i] < 3) begin
                    acc[i] += int'($signed(m_data[i*W +: W])) * top[idx[i]];
                    idx[i]++;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (entered and left at posedge + 1)
    // ------------------------------------------------------------------
    task automatic push_vec(input logic [L*W-1:0] d, input logic l);
        bit acc_ok;
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        acc_ok  = 0;
        for (int n = 0; n < 200 && !acc_ok; n++) begin
            @(negedge clk);
            acc_ok = s_ready;
            @(posedge clk);
            #1;
        end
        if (!acc_ok) begin
            failures++;
            $display("FAIL push_timeout: got no accept expected accept");
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int n = 0; n < 80 && !ok; n++) begin
            @(negedge clk);
            ok = !busy && (m_lane_valid == '0);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL idle_timeout: got busy expected idle");
        end
        @(posedge clk);
        #1;
    endtask

    // Single vector {1,2,3,4}, last, pushed at edge E.
    task automatic single_vector(input string tag);
        push_vec(32'h04030201, 1'b1);   // returns at E + 1
        @(posedge clk);                 // E+1
        @(posedge clk);                 // E+2
        @(negedge clk);
        chk({tag, "_lane0"}, {m_lane_valid, m_data[7:0]}, {4'b0001, 8'd1});
        @(negedge clk);
        chk({tag, "_lane1"}, {m_lane_valid, m_data[15:8]}, {4'b0010, 8'd2});
        @(negedge clk);
        chk({tag, "_lane2"}, {m_lane_valid, m_data[23:16]}, {4'b0100, 8'd3});
        @(negedge clk);
        chk({tag, "_lane3"}, {m_lane_valid, m_data[31:24]}, {4'b1000, 8'd4});
        chk({tag, "_done"}, {done, busy}, 2'b11);
        @(negedge clk);
        chk({tag, "_after"}, {done, busy}, 2'b00);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int first, second;
        logic [7:0] e0[$];
        logic [7:0] e3[$];
        bit ok;

        // Test 1: reset
        #2 rst = 1'b1;
        chk_en = 1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t1_outputs", {m_data, m_lane_valid, m_en, done, busy}, '0);
        chk("t1_ready", s_ready, 1'b1);
        @(posedge clk);
        #1;

        // Test 2: single vector latency
        single_vector("t2");
        wait_idle();

        // Test 3: three vectors into per-lane MACs
        for (int i = 0; i < L; i++) begin
            acc[i] = 0;
            idx[i] = 0;
        end
        mac_on = 1;
        push_vec(32'h02020202, 1'b0);
        push_vec(32'h04040404, 1'b0);
        push_vec(32'h06060606, 1'b1);
        wait_idle();
        mac_on = 0;
        for (int i = 0; i < L; i++) chk($sformatf("t3_acc%0d", i), acc[i], 4);

        // Test 4: hold fills the FIFO, release drains in order
        r0.delete();
        r3.delete();
        rec  = 1;
        hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push_vec({8'(40 + k), 8'(30 + k), 8'(20 + k), 8'(10 + k)}, 1'b0);
        end
        s_data  = {8'd44, 8'd34, 8'd24, 8'd14};
        s_last  = 1'b1;
        s_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_ready_low", s_ready, 1'b0);
            chk("t4_en_low", m_en, 1'b0);
        end
        @(posedge clk);
        #1 hold = 1'b0;
        push_vec({8'd44, 8'd34, 8'd24, 8'd14}, 1'b1);
        wait_idle();
        rec = 0;
        e0 = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14};
        e3 = '{8'd40, 8'd41, 8'd42, 8'd43, 8'd44};
        chk("t4_count0", r0.size(), 5);
        chk("t4_count3", r3.size(), 5);
        ok = (r0.size() == 5) && (r3.size() == 5);
        for (int k = 0; k < 5 && ok; k++) begin
            chk($sformatf("t4_lane0_%0d", k), r0[k], e0[k]);
            chk($sformatf("t4_lane3_%0d", k), r3[k], e3[k]);
        end

        // Test 5: two-cycle gap between pushes
        r0.delete();
        vtr.delete();
        rec = 1;
        push_vec(32'h00000014, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        push_vec(32'h00000015, 1'b1);
        wait_idle();
        rec = 0;
        first  = -1;
        second = -1;
        foreach (vtr[k]) begin
            if (vtr[k] && first < 0) first = k;
            else if (vtr[k] && second < 0) second = k;
        end
        chk("t5_gap", second - first - 1, 2);
        chk("t5_vals", {r0.size() == 2 ? r0[0] : 8'hxx, r0.size() == 2 ? r0[1] : 8'hxx},
            {8'd20, 8'd21});
`ifdef MACSKEW_STATS_EN
        chk("t5_bubble_cnt", bubble_cnt, 16'd2);
`endif

        // Test 6: reset with lanes 1-3 in flight
        push_vec(32'h04030201, 1'b1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("t6_pre_lane0", m_lane_valid, 4'b0001);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_clear", {m_data, m_lane_valid, m_en, done, busy}, '0);
        done_cnt = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 8; k++) @(posedge clk);
        #1;
        chk("t6_no_done", done_cnt, 0);
        single_vector("t6");
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
